// File: rtl/rotate_tick_if.sv
// Signal bundle between the rotate tick generator and its environment.
// btn_step exists only when ROTATE_STEP_EN is defined.
interface rotate_tick_if;
  logic       btn_run;
  logic [1:0] speed;
`ifdef ROTATE_STEP_EN
  logic       btn_step;
`endif
  logic       en;
  logic       running;

`ifdef ROTATE_STEP_EN
  modport master (output btn_run, output speed, output btn_step, input en, input running);
  modport slave  (input btn_run, input speed, input btn_step, output en, output running);
`else
  modport master (output btn_run, output speed, input en, input running);
  modport slave  (input btn_run, input speed, output en, output running);
`endif
endinterface

// File: rtl/rotate_tick_gen.sv
// Run/pause gated enable-pulse divider for the LED rotator, with debounced buttons.
// Optional single-step button is compiled in when ROTATE_STEP_EN is defined.
module rotate_tick_gen #(
  parameter int unsigned DIV_BASE    = 50_000_000,
  parameter int unsigned DBNC_CYCLES = 500_000,
  parameter int unsigned CNT_W       = 32
) (
  input logic          clk,
  input logic          rst,
  rotate_tick_if.slave tick
);

`ifdef ROTATE_STEP_EN
  localparam int unsigned NumBtn = 2;
`else
  localparam int unsigned NumBtn = 1;
`endif

  localparam logic [CNT_W-1:0] DbncLast = CNT_W'(DBNC_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivBase  = CNT_W'(DIV_BASE);

  typedef enum logic [0:0] {StPause, StRun} state_e;

  logic [NumBtn-1:0] btn_raw;
  logic [NumBtn-1:0] sync1_q, sync2_q;
  logic [NumBtn-1:0] stable_q, stable_d, stable_prev_q;
  logic [NumBtn-1:0] press;
  logic [CNT_W-1:0]  dbnc_q [NumBtn];
  logic [CNT_W-1:0]  dbnc_d [NumBtn];

  logic              run_press, step_press;
  logic [CNT_W-1:0]  term;
  logic [CNT_W-1:0]  cnt_q;
  logic              en_q, running_q;
  state_e            state_q;

`ifdef ROTATE_STEP_EN
  assign btn_raw    = {tick.btn_step, tick.btn_run};
  assign step_press = press[1];
`else
  assign btn_raw    = tick.btn_run;
  assign step_press = 1'b0;
`endif
  assign run_press  = press[0];

  // Counter only runs while the synced level disagrees with the accepted level.
  always_comb begin
    for (int b = 0; b < int'(NumBtn); b++) begin
      stable_d[b] = stable_q[b];
      dbnc_d[b]   = '0;
      if (sync2_q[b] != stable_q[b]) begin
        if (dbnc_q[b] == DbncLast) begin
          stable_d[b] = sync2_q[b];
        end else begin
          dbnc_d[b] = dbnc_q[b] + CNT_W'(1);
        end
      end
    end
  end

  assign press = stable_q & ~stable_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      for (int b = 0; b < int'(NumBtn); b++) begin
        dbnc_q[b] <= '0;
      end
    end else begin
      sync1_q       <= btn_raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      for (int b = 0; b < int'(NumBtn); b++) begin
        dbnc_q[b] <= dbnc_d[b];
      end
    end
  end

  assign term = (DivBase >> tick.speed) - CNT_W'(1);

  // A run press always wins the state; a terminal count in the same cycle still emits en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StPause;
      running_q <= 1'b0;
      en_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        StRun: begin
          if (cnt_q >= term) begin
            cnt_q <= '0;
            en_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            en_q  <= 1'b0;
          end
          if (run_press) begin
            state_q   <= StPause;
            running_q <= 1'b0;
            cnt_q     <= '0;
          end
        end
        default: begin
          en_q <= step_press;
          if (run_press) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign tick.en      = en_q;
  assign tick.running = running_q;

endmodule

// File: tb/tb_rotate_tick_gen.sv
// Directed bench for rotate_tick_gen with a cycle-level reference model.
// Build with ROTATE_STEP_EN defined to also exercise the single-step button.
module tb_rotate_tick_gen;
  localparam int DivBase = 16;
  localparam int Dbnc    = 4;
`ifdef ROTATE_STEP_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  rotate_tick_if bus ();

  rotate_tick_gen #(
    .DIV_BASE   (DivBase),
    .DBNC_CYCLES(Dbnc),
    .CNT_W      (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tick(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw-sample history, accepted level, pending press, and the
  // elapsed cycles since the last pulse or run start.
  bit hist [NB][Dbnc+2];
  bit m_stab [NB];
  bit m_pend [NB];
  bit raw_s [NB];
  bit m_run, m_en, run_p, step_p, all_diff;
  int m_elapsed, per;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NB; b++) begin
        for (int k = 0; k < Dbnc + 2; k++) hist[b][k] = 1'b0;
        m_stab[b] = 1'b0;
        m_pend[b] = 1'b0;
      end
      m_run     = 1'b0;
      m_en      = 1'b0;
      m_elapsed = 0;
    end else begin
      raw_s[0] = bus.btn_run;
`ifdef ROTATE_STEP_EN
      raw_s[1] = bus.btn_step;
      step_p   = m_pend[1];
`else
      step_p   = 1'b0;
`endif
      run_p = m_pend[0];
      per   = DivBase >> bus.speed;
      m_en  = 1'b0;
      if (m_run) begin
        if (m_elapsed >= per - 1) begin
          m_en      = 1'b1;
          m_elapsed = 0;
        end else begin
          m_elapsed++;
        end
      end else begin
        m_en = step_p;
      end
      if (run_p) begin
        m_run     = !m_run;
        m_elapsed = 0;
      end
      // Accepted level flips once the synced input (raw from two edges back) has
      // disagreed with it for Dbnc consecutive samples.
      for (int b = 0; b < NB; b++) begin
        m_pend[b] = 1'b0;
        all_diff  = 1'b1;
        for (int k = 1; k <= Dbnc; k++) begin
          if (hist[b][k] == m_stab[b]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_stab[b] = !m_stab[b];
          m_pend[b] = m_stab[b];
        end
        for (int k = Dbnc + 1; k > 0; k--) hist[b][k] = hist[b][k-1];
        hist[b][0] = raw_s[b];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on && rst) begin
      check("model_en", bus.en, m_en);
      check("model_running", bus.running, m_run);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_en(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.en !== 1'b1 && n < max);
    if (bus.en !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL wait_en_timeout actual=%0d required=<%0d cycles", n, max);
    end
  endtask

  task automatic count_en(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.en === 1'b1) c++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c;
    bus.btn_run = 1'b0;
    bus.speed   = 2'd0;
`ifdef ROTATE_STEP_EN
    bus.btn_step = 1'b0;
`endif
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    chk_on = 1'b1;
    #1;
    check("reset_en", bus.en, 0);
    check("reset_running", bus.running, 0);
    count_en(100, c);
    check("idle_no_en", c, 0);

    // Clean run press at slowest rate.
    bus.btn_run = 1'b1;
    tick(6);
    check("run_lat_pre", bus.running, 0);
    tick(1);
    check("run_lat", bus.running, 1);
    tick(13);
    bus.btn_run = 1'b0;
    wait_en(40, n);
    check("first_en_s0", n, 3);
    wait_en(40, n);
    check("period_s0", n, 16);

    // Count is 10 when speeding up to term=1.
    tick(10);
    bus.speed = 2'd3;
    wait_en(40, n);
    check("fast_switch", n, 1);
    wait_en(40, n);
    check("period_s3_a", n, 2);
    wait_en(40, n);
    check("period_s3_b", n, 2);

    // Bounces shorter than the debounce window are ignored.
    repeat (2) begin
      bus.btn_run = 1'b1;
      tick(2);
      bus.btn_run = 1'b0;
      tick(2);
    end
    tick(10);
    check("bounce_running", bus.running, 1);
    bus.btn_run = 1'b1;
    tick(7);
    check("pause_running", bus.running, 0);
    tick(13);
    bus.btn_run = 1'b0;
    count_en(40, c);
    check("pause_no_en", c, 0);

    // Re-run at speed 2: first pulse lands term+1 after the state change, so cnt restarted at 0.
    bus.speed   = 2'd2;
    bus.btn_run = 1'b1;
    wait_en(40, n);
    check("first_en_s2", n, 11);
    tick(9);
    bus.btn_run = 1'b0;
    wait_en(40, n);
    wait_en(40, n);
    check("period_s2", n, 4);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_en", bus.en, 0);
    check("async_rst_running", bus.running, 0);
    tick(2);
    rst = 1'b1;
    count_en(40, c);
    check("post_rst_no_en", c, 0);
    check("post_rst_running", bus.running, 0);

`ifdef ROTATE_STEP_EN
    repeat (3) begin
      bus.btn_step = 1'b1;
      tick(6);
      check("step_pre", bus.en, 0);
      tick(1);
      check("step_pulse", bus.en, 1);
      tick(1);
      check("step_single", bus.en, 0);
      tick(6);
      bus.btn_step = 1'b0;
      count_en(10, c);
      check("step_release", c, 0);
    end
    check("step_running", bus.running, 0);

    bus.btn_run = 1'b1;
    wait_en(40, n);
    check("step_run_first", n, 11);
    tick(9);
    bus.btn_run = 1'b0;
    wait_en(40, n);
    bus.btn_step = 1'b1;
    repeat (5) begin
      wait_en(40, n);
      check("step_in_run_period", n, 4);
    end
    bus.btn_step = 1'b0;
    repeat (3) begin
      wait_en(40, n);
      check("step_in_run_after", n, 4);
    end
`endif

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
